// File: rtl/rect_scroller.sv
// rect_scroller: draws, holds, erases and vertically moves a solid
// rectangle on the 160x120 adapter, one pixel per clock.
//
// Ports:
//   clock, reset_n    system clock, synchronous active-low reset
//   go                start request, honoured only while idle
//   stop              stop request, ends the animation after the next erase
//   dir               0 = move up, 1 = move down (used in the move cycle)
//   in_x, in_y        top-left corner, loaded on go
//   colour            draw colour, loaded on go
//   out_x, out_y      current pixel coordinates
//   out_colour        colour of the current pixel
//   plot              pixel write strobe
//   busy              high whenever an animation is running
//   wrapped           one-cycle pulse when a move wraps at a screen edge
module rect_scroller #(
   parameter int unsigned RECT_W       = 40,
   parameter int unsigned RECT_H       = 10,
   parameter int unsigned SCREEN_H     = 120,
   parameter int unsigned DELAY        = 833_333,
   parameter int unsigned FRAMES       = 15,
   parameter int unsigned STEP         = 1,
   parameter logic [2:0]  ERASE_COLOUR = 3'b111
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       go,
   input  logic       stop,
   input  logic       dir,
   input  logic [7:0] in_x,
   input  logic [6:0] in_y,
   input  logic [2:0] colour,
   output logic [7:0] out_x,
   output logic [6:0] out_y,
   output logic [2:0] out_colour,
   output logic       plot,
   output logic       busy,
   output logic       wrapped
);

   // Counter widths, kept at least one bit wide for degenerate sizes.
   localparam int QXW = (RECT_W > 1) ? $clog2(RECT_W) : 1;
   localparam int QYW = (RECT_H > 1) ? $clog2(RECT_H) : 1;
   localparam int DW  = (DELAY  > 1) ? $clog2(DELAY)  : 1;
   localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   localparam logic [QXW-1:0] QX_LAST  = QXW'(RECT_W - 1);
   localparam logic [QYW-1:0] QY_LAST  = QYW'(RECT_H - 1);
   localparam logic [DW-1:0]  DLY_LAST = DW'(DELAY - 1);
   localparam logic [FW-1:0]  FRM_LAST = FW'(FRAMES - 1);

   // Lowest top row that still keeps the whole rectangle on screen.
   localparam logic [7:0] LIMIT8 = 8'(SCREEN_H - RECT_H);
   localparam logic [6:0] LIMIT7 = 7'(SCREEN_H - RECT_H);
   localparam logic [7:0] STEP8  = 8'(STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW,
      S_WAIT,
      S_ERASE,
      S_MOVE
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     x0_q, x0_d;
   logic [6:0]     y_q, y_d;
   logic [2:0]     col_q, col_d;
   logic [QXW-1:0] qx_q, qx_d;
   logic [QYW-1:0] qy_q, qy_d;
   logic [DW-1:0]  dly_q, dly_d;
   logic [FW-1:0]  frm_q, frm_d;
   logic           stop_req_q, stop_req_d;

   logic           scan_last;
   logic           frame_tick;
   logic           frm_last;
   logic [7:0]     y8;
   logic [7:0]     y_sum;
   logic [6:0]     move_y;
   logic           move_wrap;

   assign scan_last  = (qx_q == QX_LAST) && (qy_q == QY_LAST);
   assign frame_tick = (dly_q == '0);
   assign frm_last   = (frm_q == FRM_LAST);

   // Vertical step with wrap, evaluated in 8 bits so y+STEP cannot overflow.
   always_comb begin
      y8        = {1'b0, y_q};
      y_sum     = y8 + STEP8;
      move_wrap = 1'b0;
      move_y    = y_q;
      if (!dir) begin
         move_wrap = (y8 < STEP8);
         move_y    = move_wrap ? LIMIT7 : 7'(y8 - STEP8);
      end else begin
         move_wrap = (y_sum > LIMIT8);
         move_y    = move_wrap ? 7'd0 : 7'(y_sum);
      end
   end

   // State register and datapath flops.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         x0_q       <= '0;
         y_q        <= '0;
         col_q      <= '0;
         qx_q       <= '0;
         qy_q       <= '0;
         dly_q      <= '0;
         frm_q      <= '0;
         stop_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y_q        <= y_d;
         col_q      <= col_d;
         qx_q       <= qx_d;
         qy_q       <= qy_d;
         dly_q      <= dly_d;
         frm_q      <= frm_d;
         stop_req_q <= stop_req_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go) state_d = S_DRAW;
         S_DRAW:  if (scan_last) state_d = S_WAIT;
         S_WAIT:  if (frame_tick && frm_last) state_d = S_ERASE;
         S_ERASE: if (scan_last) state_d = S_MOVE;
         S_MOVE:  state_d = stop_req_q ? S_IDLE : S_DRAW;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values.
   always_comb begin
      x0_d       = x0_q;
      y_d        = y_q;
      col_d      = col_q;
      qx_d       = qx_q;
      qy_d       = qy_q;
      dly_d      = dly_q;
      frm_d      = frm_q;
      stop_req_d = stop_req_q;

      // Any stop seen while running is remembered until the next idle.
      if (state_q != S_IDLE && stop) stop_req_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               x0_d       = in_x;
               y_d        = in_y;
               col_d      = colour;
               qx_d       = '0;
               qy_d       = '0;
               stop_req_d = stop;
            end
         end
         S_DRAW, S_ERASE: begin
            if (qx_q == QX_LAST) begin
               qx_d = '0;
               qy_d = (qy_q == QY_LAST) ? '0 : qy_q + QYW'(1);
            end else begin
               qx_d = qx_q + QXW'(1);
            end
            // Arm the frame-delay counters for the hold that follows.
            if (state_q == S_DRAW && scan_last) begin
               dly_d = DLY_LAST;
               frm_d = '0;
            end
         end
         S_WAIT: begin
            if (frame_tick) begin
               dly_d = DLY_LAST;
               frm_d = frm_last ? '0 : frm_q + FW'(1);
            end else begin
               dly_d = dly_q - DW'(1);
            end
         end
         S_MOVE: begin
            if (stop_req_q) begin
               stop_req_d = 1'b0;
            end else begin
               y_d = move_y;
            end
         end
         default: begin
         end
      endcase
   end

   // Outputs.
   always_comb begin
      plot       = 1'b0;
      busy       = 1'b1;
      wrapped    = 1'b0;
      out_colour = col_q;
      out_x      = x0_q + 8'(qx_q);
      out_y      = y_q + 7'(qy_q);
      unique case (state_q)
         S_IDLE:  busy = 1'b0;
         S_DRAW:  plot = 1'b1;
         S_WAIT:  plot = 1'b0;
         S_ERASE: begin
            plot       = 1'b1;
            out_colour = ERASE_COLOUR;
         end
         S_MOVE:  wrapped = !stop_req_q && move_wrap;
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rect_scroller.sv
// tb_rect_scroller: randomized self-checking bench for rect_scroller
// against a frame-level model of the expected pixel stream.
module tb_rect_scroller;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int SH  = 120;
   localparam int DL  = 3;
   localparam int FR  = 2;
   localparam int ST  = 1;
   localparam int EC  = 7;
   localparam int NPX = W * H;
   localparam int NWT = FR * DL;
   localparam int PER = 2 * NPX + NWT + 1;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       go = 1'b0;
   logic       stop = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] in_x = '0;
   logic [6:0] in_y = '0;
   logic [2:0] colour = '0;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   logic       plot;
   logic       busy;
   logic       wrapped;

   int checks = 0;
   int failures = 0;

   rect_scroller #(
      .RECT_W(W), .RECT_H(H), .SCREEN_H(SH), .DELAY(DL),
      .FRAMES(FR), .STEP(ST), .ERASE_COLOUR(3'b111)
   ) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .stop(stop),
      .dir(dir), .in_x(in_x), .in_y(in_y), .colour(colour),
      .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
      .plot(plot), .busy(busy), .wrapped(wrapped)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_plot"}, plot, 0);
      check({tag, "_wrap"}, wrapped, 0);
   endtask

   // Run one animation. dmode: 0 = up, 1 = down, 2 = random every cycle.
   // A stop pulse is placed at cycle stop_off of step stop_step.
   task automatic run_anim(input int x, input int y, input int c,
                           input bit gs, input int dmode,
                           input int stop_step, input int stop_off);
      int  cy, nxt, s, p, ex, ey, ec;
      bit  stopping, done, wr;
      in_x   = 8'(x);
      in_y   = 7'(y);
      colour = 3'(c);
      go     = 1'b1;
      stop   = gs;
      dir    = 1'b0;
      #1;
      check_idle("pre_go");
      stopping = gs;
      cy   = y;
      done = 1'b0;
      s    = 0;
      while (!done) begin
         for (int i = 0; i < PER; i++) begin
            tick();
            go     = ($urandom_range(0, 3) == 0);
            in_x   = 8'($urandom);
            in_y   = 7'($urandom);
            colour = 3'($urandom);
            dir    = (dmode == 2) ? 1'($urandom_range(0, 1)) : dmode[0];
            stop   = !stopping && s == stop_step && i == stop_off;
            #1;
            check("busy", busy, 1);
            if (i < NPX || (i >= NPX + NWT && i < PER - 1)) begin
               p  = (i < NPX) ? i : i - (NPX + NWT);
               ex = (x + p % W) % 256;
               ey = (cy + p / W) % 128;
               ec = (i < NPX) ? c : EC;
               check("plot_on", plot, 1);
               check("out_x", out_x, ex);
               check("out_y", out_y, ey);
               check("out_colour", out_colour, ec);
               check("wrap_scan", wrapped, 0);
            end else if (i < PER - 1) begin
               check("plot_wait", plot, 0);
               check("wrap_wait", wrapped, 0);
            end else begin
               check("plot_move", plot, 0);
               if (stopping) begin
                  check("wrap_stop", wrapped, 0);
                  done = 1'b1;
               end else begin
                  if (!dir) begin
                     wr  = (cy < ST);
                     nxt = wr ? SH - H : cy - ST;
                  end else begin
                     wr  = (cy + ST > SH - H);
                     nxt = wr ? 0 : cy + ST;
                  end
                  check("wrap_move", wrapped, wr);
                  cy = nxt;
               end
            end
            if (stop) stopping = 1'b1;
         end
         s++;
         if (s > 40 && !done) begin
            check("step_budget", s, 40);
            done = 1'b1;
         end
      end
      go   = 1'b0;
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_idle("after_stop");
      end
   endtask

   initial begin
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_plot", plot, 0);
      check("rst_wrap", wrapped, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_col", out_colour, 0);
      reset_n = 1'b1;
      tick();
      // stop while idle and without go is ignored
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("idle_stop");

      run_anim(10, 20, 4, 1'b0, 0, 1, 10);
      run_anim(30, 0, 2, 1'b0, 0, 1, 9);
      run_anim(70, 118, 5, 1'b0, 1, 1, 12);
      run_anim(100, 50, 1, 1'b0, 1, 1, 8);
      run_anim(10, 60, 6, 1'b1, 0, 0, 0);
      run_anim(254, 119, 3, 1'b0, 1, 2, PER - 1);

      for (int r = 0; r < 8; r++) begin
         run_anim(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, PER - 1)));
      end

      // reset in the middle of a draw
      in_x   = 8'd30;
      in_y   = 7'd40;
      colour = 3'd5;
      go     = 1'b1;
      tick();
      go = 1'b0;
      tick();
      check("mid_plot", plot, 1);
      reset_n = 1'b0;
      tick();
      check("mr_busy", busy, 0);
      check("mr_plot", plot, 0);
      check("mr_wrap", wrapped, 0);
      check("mr_x", out_x, 0);
      check("mr_y", out_y, 0);
      check("mr_col", out_colour, 0);
      reset_n = 1'b1;
      tick();
      check_idle("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rect_scroller.md
# rect_scroller

Parametrised animated-rectangle engine for the 160x120 VGA adapter path. It draws a RECT_W x RECT_H solid rectangle one pixel per clock, holds it for a programmable number of frame ticks, erases it with a background colour, then moves it vertically by STEP rows. Direction is selectable, the rectangle wraps at screen edges, and a stop request ends the animation cleanly after the next erase. Outputs drive the adapter's x/y/colour/plot inputs directly.

## Interface
- RECT_W, default 40: rectangle width in pixels (1..160).
- RECT_H, default 10: rectangle height in pixels (1..SCREEN_H).
- SCREEN_H, default 120: visible rows.
- DELAY, default 833_333: clocks per frame tick (60 Hz at 50 MHz), >= 1.
- FRAMES, default 15: frame ticks the rectangle stays visible per step, >= 1.
- STEP, default 1: rows moved per step (1..SCREEN_H-RECT_H).
- ERASE_COLOUR, default 3'b111: background colour used for erase.
- clock  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- go  in  1  start request; honoured only in IDLE.
- stop  in  1  stop request; latched on any cycle, including the go cycle.
- dir  in  1  0 = move up (y decreases), 1 = move down; sampled in MOVE.
- in_x  in  8  left column, loaded on go.
- in_y  in  7  top row, loaded on go.
- colour  in  3  draw colour, loaded on go.
- out_x  out  8  pixel column = x0 + qx (8-bit modulo, no clipping).
- out_y  out  7  pixel row = y + qy (7-bit modulo).
- out_colour  out  3  colour for current pixel.
- plot  out  1  write strobe; high only in DRAW and ERASE.
- busy  out  1  high in every state except IDLE.
- wrapped  out  1  one-cycle pulse in the MOVE cycle that wraps.

## Operation
- Registers: x0[7:0], y[6:0], col[2:0], qx (clog2 RECT_W), qy (clog2 RECT_H), delay counter (clog2 DELAY), frame counter (clog2 FRAMES), stop_req.
- States: IDLE, DRAW, WAIT, ERASE, MOVE.
- IDLE: go=1 -> load x0/y/col, clear qx/qy, stop_req<=stop, go to DRAW. Otherwise stay; stop ignored.
- DRAW: plot=1, out_colour=col; qx increments each clock, at RECT_W-1 wraps to 0 and qy increments; after pixel (RECT_W-1, RECT_H-1) clear qx/qy and go to WAIT.
- WAIT: plot=0; delay counter loaded with DELAY-1 on entry, decrements; at 0 it reloads and the frame counter increments; after FRAMES ticks go to ERASE.
- ERASE: same scan as DRAW with out_colour=ERASE_COLOUR; after last pixel go to MOVE.
- MOVE (1 cycle): if stop_req -> IDLE, y unchanged, wrapped=0. Else update y, go to DRAW.
- Arithmetic in 8 bits. Up: y < STEP -> y = SCREEN_H-RECT_H, wrapped=1; else y-STEP. Down: y+STEP > SCREEN_H-RECT_H -> y=0, wrapped=1; else y+STEP.
- stop_req set by stop=1 in any busy cycle; cleared on entry to IDLE.
- go while busy ignored; col/x0 not reloaded mid-animation.
- out_colour in IDLE/WAIT/MOVE = col (don't-care, plot low).

## Timing
- Reset: state IDLE; x0, y, col, qx, qy, counters, stop_req = 0; out_x=0, out_y=0, out_colour=0, plot=0, busy=0, wrapped=0.
- Reset mid-operation: IDLE on next edge, plot low from the following cycle; screen not cleaned.
- First plot in the cycle after go is sampled; out_x/out_y/out_colour valid same cycle as plot.
- DRAW and ERASE each exactly RECT_W*RECT_H cycles; WAIT exactly FRAMES*DELAY cycles; MOVE 1 cycle.
- Step period = 2*RECT_W*RECT_H + FRAMES*DELAY + 1 clocks.

## Test plan
Parameters RECT_W=4, RECT_H=2, DELAY=3, FRAMES=2, STEP=1, SCREEN_H=120.
- Reset, go with in_x=10, in_y=20, colour=3'b100, dir=0 -> 8 plot cycles x 10..13, y 20..21, colour 100; 6 cycles plot=0; 8 plot cycles colour 111; 1 MOVE; next DRAW at y=19.
- in_y=0, dir=0 -> wrapped pulses in MOVE, next DRAW rows 118..119.
- in_y=118, dir=1 -> wrapped pulses, next DRAW rows 0..1; in_y=50, dir=1 -> next y=51, no pulse.
- stop pulsed during WAIT -> ERASE completes (8 cycles colour 111), MOVE -> IDLE, busy=0, plot=0, no further DRAW; go and stop in same IDLE cycle -> one draw/wait/erase then IDLE.
- go with in_x=50 pulsed during DRAW -> ignored, x stays 10..13; dir toggled mid-WAIT -> only MOVE-cycle value used.
- reset_n low during DRAW -> plot=0, busy=0, all outputs at reset values next cycle.
